// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: M-extension op encodings, sequencer states and
// operand-classification helpers used by the multiply/divide sequencer.
package riscv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    endfunction

    // MUL low half is sign-agnostic, so it is simply grouped with the signed ops.
    function automatic logic op_signed_a(input muldiv_op_e op);
        return (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    endfunction

    function automatic logic op_signed_b(input muldiv_op_e op);
        return (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequencer: shift-add multiply step or
// restoring-divide step on the 2*XLEN accumulator, selected by is_div.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc_in,
    input  logic [XLEN-1:0]     opnd,
    output logic [2*XLEN-1:0]   acc_out
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN-1:0] w_sub;
    logic            w_ge;

    always_comb begin
        // Multiply: acc = {partial_hi, multiplier}; add multiplicand when LSB set, then shift right.
        w_sum    = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        // Divide: acc = {remainder, dividend/quotient}; shift left and trial-subtract the divisor.
        w_rem_sh = acc_in[2*XLEN-1:XLEN-1];
        w_ge     = (w_rem_sh >= {1'b0, opnd});
        w_sub    = w_rem_sh[XLEN-1:0] - opnd;
        if (is_div) begin
            if (w_ge) begin
                acc_out = {w_sub, acc_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {w_rem_sh[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_out = {w_sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer with pipeline stall control.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply; RUN used only by divides.
module muldiv_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic            Stall,
    output logic [XLEN-1:0] Result
);

    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    muldiv_state_e     r_state;
    muldiv_state_e     w_next;
    logic [CW-1:0]     r_count;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] w_acc_step;
    logic [XLEN-1:0]   r_opnd;
    muldiv_op_e        r_op;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_result;

    muldiv_op_e        w_op;
    logic              w_accept;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_val;
    logic              w_direct;
    logic [XLEN-1:0]   w_direct_val;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_val;

    // ---------------- Issue decode (IDLE) ----------------
    always_comb begin
        w_op       = muldiv_op_e'(Funct3);
        w_accept   = (r_state == IDLE) && Start && !Flush;
        w_sa       = op_signed_a(w_op) & SrcA[XLEN-1];
        w_sb       = op_signed_b(w_op) & SrcB[XLEN-1];
        w_abs_a    = w_sa ? (~SrcA + 1'b1) : SrcA;
        w_abs_b    = w_sb ? (~SrcB + 1'b1) : SrcB;
        w_div_zero = op_is_div(w_op) && (SrcB == '0);
        w_ovf      = (w_op == OP_DIV || w_op == OP_REM) &&
                     (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
        w_special  = w_div_zero | w_ovf;
        // Funct3[1] separates REM/REMU from DIV/DIVU among the divide ops.
        w_special_val = '0;
        if (w_div_zero) begin
            w_special_val = Funct3[1] ? SrcA : '1;
        end else if (w_ovf) begin
            w_special_val = Funct3[1] ? '0 : SrcA;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     w_fa;
    logic signed [XLEN:0]     w_fb;
    logic signed [2*XLEN-1:0] w_fprod;

    always_comb begin
        w_fa    = {w_sa, SrcA};
        w_fb    = {w_sb, SrcB};
        w_fprod = w_fa * w_fb;
        w_direct     = w_special || !op_is_div(w_op);
        w_direct_val = w_special_val;
        if (!op_is_div(w_op)) begin
            w_direct_val = (w_op == OP_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
        end
    end
`else
    always_comb begin
        w_direct     = w_special;
        w_direct_val = w_special_val;
    end
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_direct ? DONE : RUN;
                end
            end
            RUN: begin
                if (Flush) begin
                    w_next = IDLE;
                end else if (r_count == LAST) begin
                    w_next = FIX;
                end
            end
            FIX:     w_next = Flush ? IDLE : DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        Busy   = (r_state == RUN) || (r_state == FIX);
        Done   = (r_state == DONE);
        Stall  = ((r_state == IDLE) && Start) || Busy;
        Result = r_result;
    end

    // ---------------- Iteration counter ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_count <= r_count + 1'b1;
        end
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_is_div(r_op)),
        .acc_in  (r_acc),
        .opnd    (r_opnd),
        .acc_out (w_acc_step)
    );

    // ---------------- Operand / accumulator registers ----------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= w_op;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            if (op_is_div(w_op)) begin
                r_acc  <= {{XLEN{1'b0}}, w_abs_a};
                r_opnd <= w_abs_b;
            end else begin
                r_acc  <= {{XLEN{1'b0}}, w_abs_b};
                r_opnd <= w_abs_a;
            end
        end else if (r_state == RUN) begin
            r_acc <= w_acc_step;
        end
    end

    // ---------------- Sign fix-up and result select (FIX) ----------------
    always_comb begin
        w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
        w_quo  = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
        w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
        case (r_op)
            OP_MUL:                     w_fix_val = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_val = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            w_fix_val = w_quo;
            default:                    w_fix_val = w_rem;
        endcase
    end

    // Result holds until the next completing op; a flushed op leaves it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
        end else if (w_accept && w_direct) begin
            r_result <= w_direct_val;
        end else if ((r_state == FIX) && !Flush) begin
            r_result <= w_fix_val;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M cases plus random ops
// against an arithmetic reference model; monitor checks Result, latency and Stall.
module tb_muldiv_sequencer;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            Start = 1'b0;
    logic [2:0]      Funct3 = 3'd0;
    logic [XLEN-1:0] SrcA = '0;
    logic [XLEN-1:0] SrcB = '0;
    logic            Flush = 1'b0;
    logic            Busy;
    logic            Done;
    logic            Stall;
    logic [XLEN-1:0] Result;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Flush  (Flush),
        .Busy   (Busy),
        .Done   (Done),
        .Stall  (Stall),
        .Result (Result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          start;
        logic [2:0]  f;
    } exp_t;

    exp_t        sbq[$];
    int          cyc = 0;
    int          n_done = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int     ia, ib, q;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        p  = 0;
        q  = 0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = ia / ib; return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = ia % ib; return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return XLEN + 2;
    endfunction

    // Monitor: pop on every Done; while an op is outstanding Stall must stay high.
    always @(negedge clk) begin
        if (!reset) begin
            if (Done) begin
                exp_t e;
                n_done++;
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: Result=0x%08h with no op outstanding", Result);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("result_f%0d", e.f), Result, e.res);
                    chk("latency", cyc - e.start + 1, e.lat);
                    chk("stall_in_done", {31'b0, Stall}, 32'd0);
                end
            end else if (sbq.size() != 0) begin
                chk("stall_while_pending", {31'b0, Stall}, 32'd1);
            end
        end
    end

    task automatic wait_done(input int prev, input int max_cyc);
        bit seen;
        seen = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk); #1;
            if (n_done != prev) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no Done within %0d cycles", max_cyc);
            sbq.delete();
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit hold);
        exp_t e;
        int   prev;
        @(posedge clk); #1;
        Start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
        e.res = exp; e.lat = exp_lat(f, a, b); e.start = cyc + 1; e.f = f;
        sbq.push_back(e);
        prev = n_done;
        @(posedge clk); #1;
        if (!hold) Start = 1'b0;
        wait_done(prev, 100);
        if (hold) begin
            @(posedge clk); #1;
            Start = 1'b0;
        end
        last_res = exp;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"},   {31'b0, Busy},  32'd0);
        chk({tag, "_done"},   {31'b0, Done},  32'd0);
        chk({tag, "_stall"},  {31'b0, Stall}, 32'd0);
        chk({tag, "_result"}, Result,         32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        logic [2:0]  f;
        logic [31:0] a, b;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed arithmetic cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 0);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 0);
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'd5, 32'd0, 32'd5, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);

        // Flush a DIV at count 10: no Done, Result retained
        @(posedge clk); #1;
        Start = 1'b1; Funct3 = 3'd4; SrcA = 32'd1000; SrcB = 32'd3;
        prev = n_done;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (10) @(posedge clk);
        #1 Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0;
        @(negedge clk);
        chk("flush_busy",   {31'b0, Busy},  32'd0);
        chk("flush_stall",  {31'b0, Stall}, 32'd0);
        chk("flush_result", Result, last_res);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("flush_no_done", n_done - prev, 32'd0);
        chk("flush_result_hold", Result, last_res);
        run_op(3'd4, 32'd1000, 32'd3, 32'd333, 0);

        // Start and Flush together in IDLE: not accepted
        @(posedge clk); #1;
        Start = 1'b1; Flush = 1'b1; Funct3 = 3'd5; SrcA = 32'd9; SrcB = 32'd3;
        prev = n_done;
        @(posedge clk); #1;
        Start = 1'b0; Flush = 1'b0;
        @(negedge clk);
        chk("startflush_busy", {31'b0, Busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1 chk("startflush_no_done", n_done - prev, 32'd0);

        // Start held through RUN/DONE: exactly one op
        prev = n_done;
        run_op(3'd5, 32'd77, 32'd7, 32'd11, 1);
        repeat (40) @(posedge clk);
        #1 chk("held_start_one_op", n_done - prev, 32'd1);

        // Reset mid-RUN
        @(posedge clk); #1;
        Start = 1'b1; Funct3 = 3'd5; SrcA = 32'd50; SrcB = 32'd5;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("midrun_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        last_res = '0;

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 100);
                default: ;
            endcase
            run_op(f, a, b, model(f, a, b), 0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
